uart_cmd_frame_parser_32bit: RTL

//  Sits downstream of the UART top. Pulls received bytes from its RX FIFO read port and parses

---
 rtl/uart_cmd_frame_parser_32bit_pkg.sv | 23 ++
 rtl/uart_cmd_frame_parser_32bit_byte_fetch.sv | 62 ++++++
 rtl/uart_cmd_frame_parser_32bit.sv | 130 +++++++++++++
 3 files changed

// File: rtl/uart_cmd_frame_parser_32bit_pkg.sv
// Shared definitions for the UART command frame parser.
// Holds the parse/fetch state encodings and the frame geometry
// (4 data bytes carried LSB first between ADDR and CSUM).
package uart_cmd_frame_parser_32bit_pkg;

    typedef enum logic [2:0] {
        P_HUNT = 3'd0,
        P_ADDR = 3'd1,
        P_DATA = 3'd2,
        P_CSUM = 3'd3,
        P_OUT  = 3'd4
    } parse_state_t;

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_REQ  = 2'd1,
        F_WAIT = 2'd2
    } fetch_state_t;

    localparam int unsigned DATA_BYTES    = 4;
    localparam logic [1:0]  LAST_DATA_IDX = 2'(DATA_BYTES - 1);

endpackage

// File: rtl/uart_cmd_frame_parser_32bit_byte_fetch.sv
// Byte fetch engine for the UART RX FIFO read port.
// Issues a one-cycle read request, then waits up to RD_TIMEOUT cycles for
// rd_data_valid. A returned byte is presented as rx_byte with a one-cycle
// byte_stb; with no reply the request is simply re-issued.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   fetch_en          allow new requests (low while the parser holds a command)
//   abort             drop any outstanding request and return to idle
//   rd_data           byte from the RX FIFO
//   rd_data_valid     rd_data valid this cycle
//   rd_data_req       one-cycle read request pulse
//   rx_byte, byte_stb accepted byte and its strobe
module uart_cmd_frame_parser_32bit_byte_fetch
    import uart_cmd_frame_parser_32bit_pkg::*;
#(
    parameter logic [7:0] RD_TIMEOUT = 8'd16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fetch_en,
    input  logic       abort,
    input  logic [7:0] rd_data,
    input  logic       rd_data_valid,
    output logic       rd_data_req,
    output logic [7:0] rx_byte,
    output logic       byte_stb
);

    fetch_state_t state_q, state_d;
    logic [7:0]   wait_cnt_q;
    logic         wait_expired;

    assign wait_expired = (wait_cnt_q == RD_TIMEOUT - 8'd1);
    assign rd_data_req  = (state_q == F_REQ);
    // Valid is only meaningful while a request is outstanding.
    assign byte_stb     = (state_q == F_WAIT) && rd_data_valid;
    assign rx_byte      = rd_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= F_IDLE;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= (state_q == F_WAIT) ? wait_cnt_q + 8'd1 : 8'd0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            F_IDLE:  if (fetch_en) state_d = F_REQ;
            F_REQ:   state_d = F_WAIT;
            // A byte arriving on the expiry cycle is still taken (byte_stb
            // does not look at the timer); both cases return to idle.
            F_WAIT:  if (rd_data_valid || wait_expired) state_d = F_IDLE;
            default: state_d = F_IDLE;
        endcase
        if (abort) state_d = F_IDLE;
    end

endmodule

// File: rtl/uart_cmd_frame_parser_32bit.sv
// UART command frame parser.
// Pulls bytes from the UART RX FIFO and parses frames
//   [SYNC][ADDR][D0][D1][D2][D3][CSUM]   (CSUM = ADDR^D0^D1^D2^D3)
// Each good frame becomes one addr/data write command on a valid/ready port.
// Checksum mismatches and inter-byte timeouts pulse frame_err and bump a
// saturating error counter.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   rx_fifo_rd_data/_valid/_req RX FIFO read port
//   cmd_valid/cmd_ready         command handshake
//   cmd_addr, cmd_data          command payload, data = {D3,D2,D1,D0}
//   frame_err                   one-cycle error pulse
//   err_cnt                     saturating error count
module uart_cmd_frame_parser_32bit
    import uart_cmd_frame_parser_32bit_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE     = 8'h55,
    parameter logic [7:0]  RD_TIMEOUT    = 8'd16,
    parameter logic [23:0] FRAME_TIMEOUT = 24'd50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_fifo_rd_data,
    input  logic        rx_fifo_rd_data_valid,
    output logic        rx_fifo_rd_data_req,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd_addr,
    output logic [31:0] cmd_data,
    output logic        frame_err,
    output logic [15:0] err_cnt
);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    parse_state_t pstate_q, pstate_d;
    logic [7:0]   rx_byte;
    logic         byte_stb;
    logic [7:0]   csum_q;
    logic [1:0]   idx_q;
    logic [23:0]  timer_q;
    logic         in_frame;
    logic         csum_bad;
    logic         frame_tmo;

    assign in_frame  = (pstate_q == P_ADDR) || (pstate_q == P_DATA) || (pstate_q == P_CSUM);
    assign cmd_valid = (pstate_q == P_OUT);

    uart_cmd_frame_parser_32bit_byte_fetch #(
        .RD_TIMEOUT (RD_TIMEOUT)
    ) u_fetch (
        .clk           (clk),
        .rst           (rst),
        .fetch_en      (pstate_q != P_OUT),
        .abort         (frame_tmo),
        .rd_data       (rx_fifo_rd_data),
        .rd_data_valid (rx_fifo_rd_data_valid),
        .rd_data_req   (rx_fifo_rd_data_req),
        .rx_byte       (rx_byte),
        .byte_stb      (byte_stb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pstate_q <= P_HUNT;
        else     pstate_q <= pstate_d;
    end

    always_comb begin
        pstate_d  = pstate_q;
        csum_bad  = 1'b0;
        frame_tmo = 1'b0;
        case (pstate_q)
            P_HUNT: if (byte_stb && rx_byte == SYNC_BYTE) pstate_d = P_ADDR;
            P_ADDR, P_DATA, P_CSUM: begin
                // An accepted byte always beats a timer expiring in the same cycle.
                if (byte_stb) begin
                    if (pstate_q == P_ADDR) begin
                        pstate_d = P_DATA;
                    end else if (pstate_q == P_DATA) begin
                        if (idx_q == LAST_DATA_IDX) pstate_d = P_CSUM;
                    end else if (rx_byte == csum_q) begin
                        pstate_d = P_OUT;
                    end else begin
                        pstate_d = P_HUNT;
                        csum_bad = 1'b1;
                    end
                end else if (timer_q == FRAME_TIMEOUT - 24'd1) begin
                    pstate_d  = P_HUNT;
                    frame_tmo = 1'b1;
                end
            end
            P_OUT:   if (cmd_ready) pstate_d = P_HUNT;
            default: pstate_d = P_HUNT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_addr  <= 8'd0;
            cmd_data  <= 32'd0;
            csum_q    <= 8'd0;
            idx_q     <= 2'd0;
            timer_q   <= 24'd0;
            frame_err <= 1'b0;
            err_cnt   <= 16'd0;
        end else begin
            frame_err <= csum_bad | frame_tmo;
            if (csum_bad || frame_tmo) err_cnt <= sat_inc16(err_cnt);

            // Timer measures idle cycles since the last accepted byte of a frame.
            if (byte_stb || !in_frame) timer_q <= 24'd0;
            else                       timer_q <= timer_q + 24'd1;

            if (byte_stb) begin
                if (pstate_q == P_ADDR) begin
                    cmd_addr <= rx_byte;
                    csum_q   <= rx_byte;
                    idx_q    <= 2'd0;
                end else if (pstate_q == P_DATA) begin
                    cmd_data[{idx_q, 3'b000} +: 8] <= rx_byte;
                    csum_q <= csum_q ^ rx_byte;
                    idx_q  <= idx_q + 2'd1;
                end
            end
        end
    end

endmodule
